seq_gen: RTL

//   Serial bit-sequence generator, transmit side of the serial-pattern detector path.

---
 rtl/seq_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// seq_gen - serial bit-sequence generator (transmit side of the pattern detector path)
//
// Captures a parallel pattern when start is seen in IDLE and shifts it out MSB-first,
// one bit per p_clk_in cycle, for rep+1 frames separated by GAP idle cycles.
// Every output comes straight from a flop, so dout only moves just after a posedge.
//
// Ports
//   p_clk_in     in   1      clock, all state on posedge
//   p_rst        in   1      asynchronous active-high reset
//   start        in   1      transfer request, honoured only in IDLE
//   pattern      in   PAT_W  frame bits; frame = pattern[L-1:0], bit L-1 sent first
//   pat_len      in   LEN_W  frame length L (0 or > PAT_W means PAT_W)
//   rep          in   CNT_W  extra frames; total frames = rep+1
//   dout         out  1      serial data
//   dout_valid   out  1      dout carries a pattern bit
//   frame_start  out  1      first bit of a frame is on dout
//   busy         out  1      transfer in progress
//   done         out  1      one-cycle pulse after the final bit
module seq_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             p_clk_in,
    input  logic             p_rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    // The gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : {GAP_W{1'b0}};

    logic [1:0]       state_q,      state_d;
    logic [PAT_W-1:0] pat_q,        pat_d;        // frame, left-aligned (first bit at MSB)
    logic [PAT_W-1:0] sh_q,         sh_d;         // remaining bits of the current frame
    logic [LEN_W-1:0] len_m1_q,     len_m1_d;     // L-1, reload value of bits_left
    logic [LEN_W-1:0] bits_left_q,  bits_left_d;  // bits still to send after the one on dout
    logic [CNT_W-1:0] frames_q,     frames_d;     // frames still to send after the current one
    logic [GAP_W-1:0] gap_q,        gap_d;
    logic             dout_q,       dout_d;
    logic             valid_q,      valid_d;
    logic             fs_q,         fs_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    logic [LEN_W-1:0] eff_len_s;
    logic [PAT_W-1:0] aligned_s;

    // Effective frame length and input pattern left-aligned so bit L-1 sits at the MSB.
    always_comb begin
        if ((pat_len == {LEN_W{1'b0}}) || (pat_len > FULL_LEN)) begin
            eff_len_s = FULL_LEN;
        end else begin
            eff_len_s = pat_len;
        end
        aligned_s = pattern << (FULL_LEN - eff_len_s);
    end

    // Next-state and next-output logic of the IDLE / SHIFT / GAP controller.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        sh_d        = sh_q;
        len_m1_d    = len_m1_q;
        bits_left_d = bits_left_q;
        frames_d    = frames_q;
        gap_d       = gap_q;
        dout_d      = 1'b0;
        valid_d     = 1'b0;
        fs_d        = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Everything the transfer needs is captured here; inputs are ignored later.
                    state_d     = ST_SHIFT;
                    pat_d       = aligned_s;
                    sh_d        = aligned_s << 1;
                    len_m1_d    = eff_len_s - LEN_ONE;
                    bits_left_d = eff_len_s - LEN_ONE;
                    frames_d    = rep;
                    dout_d      = aligned_s[PAT_W-1];
                    valid_d     = 1'b1;
                    fs_d        = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (bits_left_q != {LEN_W{1'b0}}) begin
                    sh_d        = sh_q << 1;
                    bits_left_d = bits_left_q - LEN_ONE;
                    dout_d      = sh_q[PAT_W-1];
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                end else if (frames_q != {CNT_W{1'b0}}) begin
                    frames_d = frames_q - CNT_ONE;
                    busy_d   = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        // Back-to-back: next frame's first bit follows immediately.
                        sh_d        = pat_q << 1;
                        bits_left_d = len_m1_q;
                        dout_d      = pat_q[PAT_W-1];
                        valid_d     = 1'b1;
                        fs_d        = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_q == {GAP_W{1'b0}}) begin
                    state_d     = ST_SHIFT;
                    sh_d        = pat_q << 1;
                    bits_left_d = len_m1_q;
                    dout_d      = pat_q[PAT_W-1];
                    valid_d     = 1'b1;
                    fs_d        = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and never produces done.
    always_ff @(posedge p_clk_in or posedge p_rst) begin
        if (p_rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= {PAT_W{1'b0}};
            sh_q        <= {PAT_W{1'b0}};
            len_m1_q    <= {LEN_W{1'b0}};
            bits_left_q <= {LEN_W{1'b0}};
            frames_q    <= {CNT_W{1'b0}};
            gap_q       <= {GAP_W{1'b0}};
            dout_q      <= 1'b0;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            sh_q        <= sh_d;
            len_m1_q    <= len_m1_d;
            bits_left_q <= bits_left_d;
            frames_q    <= frames_d;
            gap_q       <= gap_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            fs_q        <= fs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
